// File: rtl/stackram_pkg.sv
// Shared constants and types for the stack register-file RAM.
package stackram_pkg;
  localparam int STACK_WIDTH = 12;
  localparam int STACK_DEPTH = 4;
  localparam int STACK_AW    = 2;

  typedef logic [STACK_WIDTH-1:0] stack_word_t;
  typedef logic [STACK_AW-1:0]    stack_addr_t;
endpackage

// File: rtl/stackram_word.sv
// One stack word: a WIDTH-bit flop register with async clear and load enable.
module stackram_word
  import stackram_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load on enable, clear immediately on reset regardless of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/stackram.sv
// Stack RAM: DEPTH x WIDTH flop array, one shared address for read and write.
// Read is combinational by default; define STACKRAM_READ_REG_EN to register q
// (1-cycle latency, read-first on same-address read-during-write).
module stackram
  import stackram_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = STACK_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    a,
  input  logic [WIDTH-1:0] d,
  input  logic             we,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0]            wsel;
  logic [DEPTH-1:0][WIDTH-1:0] words;
  logic [WIDTH-1:0]            rd;

  // One-hot write select from the address, gated by we.
  always_comb begin
    wsel = '0;
    if (we) wsel[a] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    stackram_word #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .rst (rst),
      .en  (wsel[i]),
      .d   (d),
      .q   (words[i])
    );
  end

  // DEPTH:1 read mux; a is always in range so no default case is needed.
  always_comb begin
    rd = words[a];
  end

`ifdef STACKRAM_READ_REG_EN
  // Registered read samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= rd;
  end
`else
  // Combinational read: no bypass from d, so a write shows only after the edge.
  always_comb begin
    q = rd;
  end
`endif

endmodule

// File: tb/tb_stackram.sv
// Directed bench for stackram; follows STACKRAM_READ_REG_EN for read latency.
module tb_stackram;
  import stackram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  stack_addr_t a;
  stack_word_t d;
  logic        we;
  stack_word_t q;

  int checks = 0;
  int errors = 0;

  stackram #(.WIDTH(STACK_WIDTH), .DEPTH(STACK_DEPTH), .AW(STACK_AW)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .d   (d),
    .we  (we),
    .q   (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input stack_word_t exp, input string tag);
    checks++;
    assert (q === exp) else begin
      errors++;
      $error("FAIL %s q=%h expected=%h", tag, q, exp);
    end
  endtask

  // Present an address and check q after the build's read latency.
  task automatic rd_chk(input stack_addr_t addr, input stack_word_t exp, input string tag);
    a = addr;
`ifdef STACKRAM_READ_REG_EN
    @(posedge clk);
`endif
    #1;
    chk(exp, tag);
  endtask

  task automatic wr(input stack_addr_t addr, input stack_word_t data);
    @(negedge clk);
    a  = addr;
    d  = data;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    d   = '0;
    we  = 1'b0;
    #2;
    chk(12'h000, "reset_q");
    @(negedge clk);
    rst = 1'b0;

    // sequential fill
    for (int i = 0; i < 4; i++) wr(stack_addr_t'(i), stack_word_t'(i));
    rd_chk(2'd0, 12'h000, "fill0");
    rd_chk(2'd1, 12'h001, "fill1");
    rd_chk(2'd2, 12'h002, "fill2");
    rd_chk(2'd3, 12'h003, "fill3");

    // write disabled
    @(negedge clk);
    a = 2'd1; d = 12'hFFF; we = 1'b0;
    repeat (3) @(posedge clk);
    rd_chk(2'd1, 12'h001, "wedis1");
    rd_chk(2'd0, 12'h000, "wedis0");
    rd_chk(2'd2, 12'h002, "wedis2");
    rd_chk(2'd3, 12'h003, "wedis3");

    // same-address read-during-write
    @(negedge clk);
    a = 2'd2; d = 12'hABC; we = 1'b1;
`ifdef STACKRAM_READ_REG_EN
    @(posedge clk); #1;
    we = 1'b0;
    chk(12'h002, "rdw_after1");
    @(posedge clk); #1;
    chk(12'hABC, "rdw_after2");
`else
    #1;
    chk(12'h002, "rdw_before");
    @(posedge clk); #1;
    we = 1'b0;
    chk(12'hABC, "rdw_after");
`endif

    // full-width data
    wr(2'd3, 12'hFFF);
    wr(2'd0, 12'h800);
    rd_chk(2'd3, 12'hFFF, "full3");
    rd_chk(2'd0, 12'h800, "full0");
    rd_chk(2'd2, 12'hABC, "full2");
    rd_chk(2'd1, 12'h001, "full1");

    // async reset pulse between edges
    @(negedge clk);
    a = 2'd3;
    #1 rst = 1'b1;
    #1 chk(12'h000, "rst_pulse_q");
    #1 rst = 1'b0;
    rd_chk(2'd0, 12'h000, "rst_clr0");
    rd_chk(2'd1, 12'h000, "rst_clr1");
    rd_chk(2'd2, 12'h000, "rst_clr2");
    rd_chk(2'd3, 12'h000, "rst_clr3");

    // reset coincident with a write edge
    @(negedge clk);
    a = 2'd1; d = 12'h555; we = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    #1 chk(12'h000, "midwr_q");
    @(negedge clk);
    we  = 1'b0;
    rst = 1'b0;
    rd_chk(2'd1, 12'h000, "midwr1");
    rd_chk(2'd0, 12'h000, "midwr0");
    rd_chk(2'd2, 12'h000, "midwr2");
    rd_chk(2'd3, 12'h000, "midwr3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
